// File: rtl/change_dispenser.sv
// Coin change dispenser: pays an amount in 10/5/2/1 coins from finite stock.
// Ports: start/amount/abort control, stock_load/stock_in, coin pulses, status.
module change_dispenser #(
   parameter int PULSE_CYC  = 4,
   parameter int GAP_CYC    = 4,
   parameter int STOCK_INIT = 20
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [9:0]  amount,
   input  logic        abort,
   input  logic        stock_load,
   input  logic [31:0] stock_in,
   output logic        coin10_out,
   output logic        coin5_out,
   output logic        coin2_out,
   output logic        coin1_out,
   output logic        busy,
   output logic        done,
   output logic        short_err,
   output logic [9:0]  remain,
   output logic [31:0] stock_out
);

   localparam int MAXC = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
   localparam int CW   = $clog2(MAXC + 1);
   localparam logic [7:0] INIT = 8'(STOCK_INIT);

   typedef enum logic [2:0] {
      IDLE, SELECT, PULSE, GAP, DONE
   } state_t;

   state_t        state_q;
   logic [9:0]    rem_q;
   logic [7:0]    stock_q [4];
   logic [3:0]    coin_q;
   logic [CW-1:0] cnt_q;
   logic          abort_q;
   logic          busy_q;
   logic          done_q;
   logic          short_q;
   logic [9:0]    remain_q;

   // Index 3..0 = 10, 5, 2, 1 yuan; largest qualifying coin wins.
   logic [3:0] sel_d;
   logic [9:0] val_d;

   always_comb begin
      sel_d = 4'b0000;
      val_d = 10'd0;
      if (rem_q >= 10'd10 && stock_q[3] != 8'd0) begin
         sel_d = 4'b1000;
         val_d = 10'd10;
      end else if (rem_q >= 10'd5 && stock_q[2] != 8'd0) begin
         sel_d = 4'b0100;
         val_d = 10'd5;
      end else if (rem_q >= 10'd2 && stock_q[1] != 8'd0) begin
         sel_d = 4'b0010;
         val_d = 10'd2;
      end else if (rem_q >= 10'd1 && stock_q[0] != 8'd0) begin
         sel_d = 4'b0001;
         val_d = 10'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         rem_q    <= 10'd0;
         coin_q   <= 4'b0000;
         cnt_q    <= '0;
         abort_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         short_q  <= 1'b0;
         remain_q <= 10'd0;
         for (int i = 0; i < 4; i++) stock_q[i] <= INIT;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  rem_q    <= amount;
                  remain_q <= 10'd0;
                  short_q  <= 1'b0;
                  abort_q  <= 1'b0;
                  busy_q   <= 1'b1;
                  state_q  <= SELECT;
               end else if (stock_load) begin
                  stock_q[3] <= stock_in[31:24];
                  stock_q[2] <= stock_in[23:16];
                  stock_q[1] <= stock_in[15:8];
                  stock_q[0] <= stock_in[7:0];
               end
            end
            SELECT: begin
               // Zero remainder also yields sel_d == 0.
               if (abort || sel_d == 4'b0000) begin
                  done_q   <= 1'b1;
                  short_q  <= (rem_q != 10'd0);
                  remain_q <= rem_q;
                  state_q  <= DONE;
               end else begin
                  rem_q   <= rem_q - val_d;
                  coin_q  <= sel_d;
                  cnt_q   <= CW'(PULSE_CYC - 1);
                  state_q <= PULSE;
                  for (int i = 0; i < 4; i++)
                     if (sel_d[i]) stock_q[i] <= stock_q[i] - 8'd1;
               end
            end
            PULSE: begin
               if (abort) abort_q <= 1'b1;
               if (cnt_q == '0) begin
                  coin_q  <= 4'b0000;
                  cnt_q   <= CW'(GAP_CYC - 1);
                  state_q <= GAP;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            GAP: begin
               if (abort) abort_q <= 1'b1;
               if (cnt_q == '0) begin
                  // Abort seen anywhere in pulse/gap ends the payout here.
                  if (abort_q || abort) begin
                     done_q   <= 1'b1;
                     short_q  <= (rem_q != 10'd0);
                     remain_q <= rem_q;
                     state_q  <= DONE;
                  end else begin
                     state_q <= SELECT;
                  end
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign coin10_out = coin_q[3];
   assign coin5_out  = coin_q[2];
   assign coin2_out  = coin_q[1];
   assign coin1_out  = coin_q[0];
   assign busy       = busy_q;
   assign done       = done_q;
   assign short_err  = short_q;
   assign remain     = remain_q;
   assign stock_out  = {stock_q[3], stock_q[2], stock_q[1], stock_q[0]};

endmodule

// File: tb/tb_change_dispenser.sv
// Directed table-driven bench for change_dispenser.
// Vectors run back to back; stock carries over between them.
module tb_change_dispenser;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [9:0]  amount = 10'd0;
   logic        abort = 1'b0;
   logic        stock_load = 1'b0;
   logic [31:0] stock_in = 32'd0;
   logic        coin10_out, coin5_out, coin2_out, coin1_out;
   logic        busy, done, short_err;
   logic [9:0]  remain;
   logic [31:0] stock_out;

   int total = 0;
   int bad = 0;

   change_dispenser dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .amount     (amount),
      .abort      (abort),
      .stock_load (stock_load),
      .stock_in   (stock_in),
      .coin10_out (coin10_out),
      .coin5_out  (coin5_out),
      .coin2_out  (coin2_out),
      .coin1_out  (coin1_out),
      .busy       (busy),
      .done       (done),
      .short_err  (short_err),
      .remain     (remain),
      .stock_out  (stock_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        ld;
      logic        lds;
      logic [31:0] ldv;
      logic [9:0]  amt;
      int          ab;
      logic        junk;
      logic [31:0] eseq;
      logic        ese;
      logic [9:0]  erm;
      logic [31:0] estk;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic logic [3:0] dn(input logic [3:0] c);
      case (c)
         4'b1000: return 4'hA;
         4'b0100: return 4'h5;
         4'b0010: return 4'h2;
         4'b0001: return 4'h1;
         default: return 4'hF;
      endcase
   endfunction

   task automatic run_vec(input int id, input vec_t v);
      logic [31:0] seq = 32'd0;
      logic [3:0]  coins, prev = 4'd0;
      int          n = 0, hi = 0, gap = 0;
      logic        bad_t = 1'b0, got = 1'b0;
      logic        se = 1'b0;
      logic [9:0]  rm = 10'd0;
      string       p = $sformatf("v%0d", id);
      if (v.ld) begin
         @(negedge clk);
         stock_load = 1'b1;
         stock_in   = v.ldv;
         @(negedge clk);
         stock_load = 1'b0;
      end
      @(negedge clk);
      start  = 1'b1;
      amount = v.amt;
      if (v.lds) begin
         stock_load = 1'b1;
         stock_in   = v.ldv;
      end
      @(negedge clk);
      start      = 1'b0;
      stock_load = 1'b0;
      chk({p, " busy_after_start"}, {31'd0, busy}, 32'd1);
      chk({p, " remain_cleared"}, {21'd0, short_err, remain}, 32'd0);
      for (int c = 0; c < 3000 && !got; c++) begin
         @(negedge clk);
         abort      = 1'b0;
         start      = 1'b0;
         stock_load = 1'b0;
         coins = {coin10_out, coin5_out, coin2_out, coin1_out};
         if (coins != 4'd0) begin
            if (prev == 4'd0) begin
               n++;
               seq = {seq[27:0], dn(coins)};
               hi = 0;
               if (n > 1 && gap < 4) bad_t = 1'b1;
            end
            hi++;
            if ($countones(coins) != 1) bad_t = 1'b1;
            if (prev != 4'd0 && coins != prev) bad_t = 1'b1;
            if (hi == 2 && n == v.ab) abort = 1'b1;
            if (hi == 2 && n == 1 && v.junk) begin
               start      = 1'b1;
               amount     = 10'd5;
               stock_load = 1'b1;
               stock_in   = 32'd0;
            end
         end else begin
            if (prev != 4'd0) begin
               if (hi != 4) bad_t = 1'b1;
               gap = 0;
            end
            gap++;
         end
         prev = coins;
         if (done) begin
            got = 1'b1;
            se  = short_err;
            rm  = remain;
            if (!busy || coins != 4'd0) bad_t = 1'b1;
         end
      end
      chk({p, " done_seen"}, {31'd0, got}, 32'd1);
      chk({p, " coin_seq"}, seq, v.eseq);
      chk({p, " pulse_timing"}, {31'd0, bad_t}, 32'd0);
      chk({p, " short_err"}, {31'd0, se}, {31'd0, v.ese});
      chk({p, " remain"}, {22'd0, rm}, {22'd0, v.erm});
      @(negedge clk);
      abort = 1'b0;
      chk({p, " idle_after"}, {30'd0, busy, done}, 32'd0);
      chk({p, " stock"}, stock_out, v.estk);
   endtask

   initial begin
      vec_t r;
      logic seen;
      //           ld   lds  ldv           amt     ab junk eseq        ese  erm     estk
      vecs[0] = '{1'b0,1'b0,32'h0,        10'd18, 0,1'b0,32'hA521,   1'b0,10'd0, 32'h13131313};
      vecs[1] = '{1'b1,1'b0,32'h14001414, 10'd8,  0,1'b0,32'h2222,   1'b0,10'd0, 32'h14001014};
      vecs[2] = '{1'b1,1'b0,32'h00000002, 10'd3,  0,1'b0,32'h11,     1'b1,10'd1, 32'h00000000};
      vecs[3] = '{1'b1,1'b0,32'h14141414, 10'd30, 2,1'b0,32'hAA,     1'b1,10'd10,32'h12141414};
      vecs[4] = '{1'b0,1'b0,32'h0,        10'd0,  0,1'b0,32'h0,      1'b0,10'd0, 32'h12141414};
      vecs[5] = '{1'b0,1'b0,32'h0,        10'd7,  0,1'b1,32'h52,     1'b0,10'd0, 32'h12131314};
      vecs[6] = '{1'b1,1'b0,32'h01010101, 10'd20, 0,1'b0,32'hA521,   1'b1,10'd2, 32'h00000000};
      vecs[7] = '{1'b1,1'b0,32'h14141414, 10'd0,  0,1'b0,32'h0,      1'b0,10'd0, 32'h14141414};
      vecs[8] = '{1'b0,1'b1,32'h01020304, 10'd0,  0,1'b0,32'h0,      1'b0,10'd0, 32'h14141414};

      repeat (3) @(negedge clk);
      chk("rst coins", {28'd0, coin10_out, coin5_out, coin2_out, coin1_out}, 32'd0);
      chk("rst status", {29'd0, busy, done, short_err}, 32'd0);
      chk("rst remain", {22'd0, remain}, 32'd0);
      chk("rst stock", stock_out, 32'h14141414);
      rst_n = 1'b1;

      for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

      // Reset in the middle of the first 10-yuan pulse.
      @(negedge clk);
      start  = 1'b1;
      amount = 10'd18;
      @(negedge clk);
      start = 1'b0;
      seen  = 1'b0;
      for (int c = 0; c < 50 && !seen; c++) begin
         @(negedge clk);
         if (coin10_out) seen = 1'b1;
      end
      chk("midrst pulse_seen", {31'd0, seen}, 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst coins", {28'd0, coin10_out, coin5_out, coin2_out, coin1_out}, 32'd0);
      chk("midrst status", {29'd0, busy, done, short_err}, 32'd0);
      chk("midrst remain", {22'd0, remain}, 32'd0);
      chk("midrst stock", stock_out, 32'h14141414);
      @(negedge clk);
      rst_n = 1'b1;
      r = vecs[0];
      run_vec(9, r);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 SHALL have parameter PULSE_CYC, default 4: cycles each coin-out pulse is held high.
REQ-002 SHALL have parameter GAP_CYC, default 4: minimum low cycles after each coin-out pulse.
REQ-003 SHALL have parameter STOCK_INIT, default 20: per-denomination coin count after reset.
REQ-004 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  single-cycle request to pay out `amount`.
REQ-007 SHALL have port amount  input  10  change owed, in yuan, unsigned.
REQ-008 SHALL have port abort  input  1  single-cycle request to stop paying out.
REQ-009 SHALL have port stock_load  input  1  single-cycle request to overwrite all four stock counters.
REQ-010 SHALL have port stock_in  input  32  load value: [31:24]=10-yuan, [23:16]=5, [15:8]=2, [7:0]=1.
REQ-011 SHALL have port coin10_out, coin5_out, coin2_out, coin1_out  output  1 each  coin-eject pulses.
REQ-012 SHALL have port busy  output  1  high while a payout is in progress.
REQ-013 SHALL have port done  output  1  single-cycle pulse when a payout ends.
REQ-014 SHALL have port short_err  output  1  valid with done; high if the payout ended with remain > 0.
REQ-015 SHALL have port remain  output  10  unpaid amount; valid from done until the next start.
REQ-016 SHALL have port stock_out  output  32  current stock counters, same packing as stock_in.

Function
REQ-017 SHALL implement the states IDLE, SELECT, PULSE, GAP and DONE.
REQ-018 IDLE: if start is sampled, SHALL latch amount into the remainder register, clear remain/short_err, and go to SELECT; busy SHALL be high from the next cycle.
REQ-019 SELECT lasts one cycle. It SHALL pick the largest denomination d in {10,5,2,1} with d <= remainder and stock_d > 0.
REQ-020 SELECT, when a denomination is found: SHALL subtract d from the remainder, decrement stock_d, and go to PULSE.
REQ-021 SELECT, when the remainder is 0, or no denomination qualifies: SHALL go to DONE.
REQ-022 PULSE: the selected coinX_out SHALL be high for exactly PULSE_CYC cycles, beginning the cycle after SELECT; then the block SHALL go to GAP.
REQ-023 GAP: all coin outputs SHALL stay low for exactly GAP_CYC cycles; then the block SHALL return to SELECT.
REQ-024 Coin outputs SHALL be registered and glitch-free. At most one coin output SHALL be high at any time.
REQ-025 DONE lasts one cycle: done=1, short_err=(remainder != 0), remain=remainder, busy stays high; then the block SHALL return to IDLE with busy=0.
REQ-026 start with amount=0 SHALL pass through SELECT to DONE with no coin pulse, short_err=0 and remain=0.
REQ-027 start while busy SHALL be ignored.
REQ-028 stock_load SHALL be accepted only in IDLE, and only when start is not also asserted; otherwise it SHALL be ignored.
REQ-029 abort during SELECT SHALL go directly to DONE. abort during PULSE or GAP SHALL complete the current pulse and gap, then go to DONE instead of SELECT.
REQ-030 After an abort, remain SHALL hold the unpaid amount and short_err SHALL be 1 if remain > 0.
REQ-031 Stock counters SHALL never decrement below 0. The remainder SHALL never underflow.

Reset
REQ-032 While rst_n=0, the block SHALL force: state=IDLE, all coin outputs=0, busy=0, done=0, short_err=0, remain=0, and every stock counter=STOCK_INIT. This applies mid-pulse, with no completion of the pulse in progress.
REQ-033 After rst_n deasserts, the block SHALL accept start on the first rising edge.

Verification
REQ-034 Full stock, start with amount=18 -> coin pulses in the order 10, 5, 2, 1; each pulse high 4 cycles with ≥4 low cycles between pulses; then done with short_err=0 and remain=0; stock becomes 19/19/19/19.
REQ-035 stock_load with 5-yuan count=0, others=20, then start with amount=8 -> four coin2_out pulses; done with short_err=0; 2-yuan stock=16.
REQ-036 stock_load 10/5/2/1 = 0/0/0/2, then start with amount=3 -> two coin1_out pulses; done with short_err=1 and remain=1.
REQ-037 start with amount=30, then abort during the second coin10_out pulse -> that pulse completes its full 4 cycles; no third pulse; done with short_err=1 and remain=10.
REQ-038 rst_n pulled low mid-pulse during a payout -> coin output drops immediately; busy=0; stock reads 20 in every field; a new start then behaves as in REQ-034.
REQ-039 start asserted while busy, and stock_load asserted while busy -> both have no effect on the payout sequence or on stock_out.
